// File: rtl/clock_drift_generator_pkg.sv
// Shared types for the clock drift generator: clock-domain bundle, edge event
// flags, drift modes and default widths. Optional feature macro: CLKS_ALOT_DRIFT_OSCILLATE_EN.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage

package clks_alot_p;

  localparam int HALF_PERIOD_WIDTH_DEF = 16;
  localparam int DRIFT_WIDTH_DEF       = 8;

  typedef struct packed {
    logic rising_edge;
    logic falling_edge;
    logic any_valid_edge;
  } recovered_events_s;

  typedef enum logic [1:0] {
    DRIFT_NONE = 2'd0,
    DRIFT_UP   = 2'd1,
    DRIFT_DOWN = 2'd2,
    DRIFT_OSC  = 2'd3
  } drift_mode_e;

endpackage

// File: rtl/clock_drift_generator_drift_accumulator.sv
// Signed drift accumulator with symmetric saturation and optional triangle-wave
// oscillation (enabled by CLKS_ALOT_DRIFT_OSCILLATE_EN; otherwise mode 3 holds).
module drift_accumulator
  import clks_alot_p::*;
#(
  parameter int DRIFT_WIDTH = DRIFT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          update,
  input  logic [1:0]                    mode,
  input  logic [DRIFT_WIDTH-1:0]        step,
  input  logic [DRIFT_WIDTH-1:0]        limit,
  output logic signed [DRIFT_WIDTH-1:0] acc,
  output logic                          limit_reached
);

  localparam int EW = DRIFT_WIDTH + 2;
  // A limit above the largest positive value would let the register wrap.
  localparam logic [DRIFT_WIDTH-1:0] MAX_MAG = {1'b0, {(DRIFT_WIDTH-1){1'b1}}};

  drift_mode_e            mode_e;
  logic [DRIFT_WIDTH-1:0] lim_eff;
  logic signed [EW-1:0]   acc_ext;
  logic signed [EW-1:0]   step_pos;
  logic signed [EW-1:0]   lim_pos;
  logic signed [EW-1:0]   lim_neg;
  logic signed [EW-1:0]   delta;
  logic signed [EW-1:0]   sum;
  logic signed [EW-1:0]   sat;
  logic signed [EW-1:0]   acc_d;
  logic signed [EW-1:0]   mag_d;

`ifdef CLKS_ALOT_DRIFT_OSCILLATE_EN
  logic dir_up;
  logic dir_up_d;
`endif

  assign mode_e   = drift_mode_e'(mode);
  assign lim_eff  = (limit > MAX_MAG) ? MAX_MAG : limit;
  assign acc_ext  = {{2{acc[DRIFT_WIDTH-1]}}, acc};
  assign step_pos = {2'b00, step};
  assign lim_pos  = {2'b00, lim_eff};
  assign lim_neg  = -lim_pos;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    delta = '0;
    case (mode_e)
      DRIFT_UP:   delta = step_pos;
      DRIFT_DOWN: delta = -step_pos;
`ifdef CLKS_ALOT_DRIFT_OSCILLATE_EN
      DRIFT_OSC:  delta = dir_up ? step_pos : -step_pos;
`endif
      default:    delta = '0;
    endcase
  end

  assign sum = acc_ext + delta;
  assign sat = (sum > lim_pos) ? lim_pos : ((sum < lim_neg) ? lim_neg : sum);

  always_comb begin
    acc_d = acc_ext;
    if (clear) begin
      acc_d = '0;
    end else if (update) begin
      acc_d = sat;
    end
  end

  assign mag_d = acc_d[EW-1] ? -acc_d : acc_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      limit_reached <= 1'b0;
    end else begin
      acc           <= acc_d[DRIFT_WIDTH-1:0];
      limit_reached <= (mag_d == lim_pos);
    end
  end

`ifdef CLKS_ALOT_DRIFT_OSCILLATE_EN
  // Direction flips on the update that lands on either rail.
  always_comb begin
    dir_up_d = dir_up;
    if (clear) begin
      dir_up_d = 1'b1;
    end else if (update && (mode_e == DRIFT_OSC)) begin
      if (dir_up && (sat == lim_pos)) begin
        dir_up_d = 1'b0;
      end else if (!dir_up && (sat == lim_neg)) begin
        dir_up_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_up <= 1'b1;
    end else begin
      dir_up <= dir_up_d;
    end
  end
`endif

endmodule

// File: rtl/clock_drift_generator.sv
// Programmable clock generator whose half periods drift under a saturating
// accumulator. Mode 3 oscillation requires CLKS_ALOT_DRIFT_OSCILLATE_EN.
module clock_drift_generator
  import clks_alot_p::*;
#(
  parameter int HALF_PERIOD_WIDTH = HALF_PERIOD_WIDTH_DEF,
  parameter int DRIFT_WIDTH       = DRIFT_WIDTH_DEF
) (
  input  common_p::clk_dom_s            sys_dom_i,
  input  logic                          gen_en_i,
  input  logic                          clear_state_i,
  input  logic [HALF_PERIOD_WIDTH-1:0]  high_half_period_i,
  input  logic [HALF_PERIOD_WIDTH-1:0]  low_half_period_i,
  input  logic [1:0]                    drift_mode_i,
  input  logic [DRIFT_WIDTH-1:0]        drift_step_i,
  input  logic [HALF_PERIOD_WIDTH-1:0]  drift_interval_i,
  input  logic [DRIFT_WIDTH-1:0]        drift_limit_i,
  output logic                          io_clk_o,
  output recovered_events_s             io_events_o,
  output logic signed [DRIFT_WIDTH-1:0] accumulated_drift_o,
  output logic                          drift_limit_reached_o
);

  localparam int HPW = HALF_PERIOD_WIDTH;
  localparam int DW  = DRIFT_WIDTH;
  localparam int SW  = ((HPW > DW) ? HPW : DW) + 2;
  localparam logic signed [SW-1:0] N_MIN = SW'(1);
  localparam logic signed [SW-1:0] N_MAX = SW'({HPW{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } gen_state_e;

  logic clk;
  logic rst_n;

  gen_state_e           state;
  gen_state_e           state_d;
  logic [HPW-1:0]       half_cnt;
  logic [HPW-1:0]       half_cnt_d;
  logic [HPW-1:0]       half_load;
  logic [HPW-1:0]       edge_cnt;
  logic [HPW-1:0]       edge_cnt_d;
  logic [HPW-1:0]       base;
  logic signed [SW-1:0] base_ext;
  logic signed [SW-1:0] drift_ext;
  logic signed [SW-1:0] n_raw;
  logic signed [SW-1:0] n_clamped;
  logic                 rise_d;
  logic                 fall_d;
  logic                 update;

  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (gen_en_i) state_d = ST_HIGH;
      ST_HIGH: begin
        if (!gen_en_i)            state_d = ST_IDLE;
        else if (half_cnt == '0)  state_d = ST_LOW;
      end
      ST_LOW: begin
        if (!gen_en_i)            state_d = ST_IDLE;
        else if (half_cnt == '0)  state_d = ST_HIGH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dropping to IDLE is not an edge, so it raises no event.
  assign rise_d = (state_d == ST_HIGH) && (state != ST_HIGH);
  assign fall_d = (state_d == ST_LOW) && (state == ST_HIGH);

  // Length of the half period being entered uses the drift from before this edge.
  assign base      = (state_d == ST_HIGH) ? high_half_period_i : low_half_period_i;
  assign base_ext  = {{(SW-HPW){1'b0}}, base};
  assign drift_ext = {{(SW-DW){accumulated_drift_o[DW-1]}}, accumulated_drift_o};
  assign n_raw     = base_ext + drift_ext;
  assign n_clamped = (n_raw < N_MIN) ? N_MIN : ((n_raw > N_MAX) ? N_MAX : n_raw);
  assign half_load = n_clamped[HPW-1:0] - HPW'(1);

  always_comb begin
    half_cnt_d = half_cnt;
    if (rise_d || fall_d) begin
      half_cnt_d = half_load;
    end else if ((state_d != ST_IDLE) && (half_cnt != '0)) begin
      half_cnt_d = half_cnt - HPW'(1);
    end
  end

  always_comb begin
    update     = 1'b0;
    edge_cnt_d = edge_cnt;
    if (clear_state_i) begin
      edge_cnt_d = '0;
    end else if ((rise_d || fall_d) && (drift_interval_i != '0)) begin
      if ((edge_cnt + HPW'(1)) >= drift_interval_i) begin
        update     = 1'b1;
        edge_cnt_d = '0;
      end else begin
        edge_cnt_d = edge_cnt + HPW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      half_cnt    <= '0;
      edge_cnt    <= '0;
      io_clk_o    <= 1'b0;
      io_events_o <= '0;
    end else begin
      state       <= state_d;
      half_cnt    <= half_cnt_d;
      edge_cnt    <= edge_cnt_d;
      io_clk_o    <= (state_d == ST_HIGH);
      io_events_o <= '{rising_edge: rise_d, falling_edge: fall_d, any_valid_edge: rise_d | fall_d};
    end
  end

  drift_accumulator #(
    .DRIFT_WIDTH (DW)
  ) u_drift_accumulator (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear_state_i),
    .update        (update),
    .mode          (drift_mode_i),
    .step          (drift_step_i),
    .limit         (drift_limit_i),
    .acc           (accumulated_drift_o),
    .limit_reached (drift_limit_reached_o)
  );

endmodule

// File: tb/tb_clock_drift_generator.sv
// Directed bench for clock_drift_generator: steady clock, ramps, oscillation,
// stop/clear and async reset. Oscillation expectations follow CLKS_ALOT_DRIFT_OSCILLATE_EN.
module tb_clock_drift_generator;
  import clks_alot_p::*;

  localparam int HPW = 16;
  localparam int DW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  common_p::clk_dom_s sys_dom;

  logic                 gen_en;
  logic                 clear_state;
  logic [HPW-1:0]       high_hp;
  logic [HPW-1:0]       low_hp;
  logic [1:0]           mode;
  logic [DW-1:0]        step;
  logic [HPW-1:0]       interval;
  logic [DW-1:0]        limit;
  logic                 io_clk;
  recovered_events_s    events;
  logic signed [DW-1:0] acc;
  logic                 reached;

  int total = 0;
  int bad   = 0;

  int ru_len[10] = '{10, 10, 11, 11, 12, 12, 13, 13, 13, 13};
  int ru_acc[10] = '{0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
  int rd_len[6]  = '{2, 1, 1, 1, 1, 1};
  int rd_acc[6]  = '{-4, -8, -8, -8, -8, -8};
`ifdef CLKS_ALOT_DRIFT_OSCILLATE_EN
  int os_len[8]  = '{3, 5, 7, 5, 3, 1, 1, 1};
  int os_acc[8]  = '{2, 4, 2, 0, -2, -4, -2, 0};
`else
  int os_len[8]  = '{3, 3, 3, 3, 3, 3, 3, 3};
  int os_acc[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

  assign sys_dom = '{clk: clk, rst_n: rst_n};
  always #5 clk = ~clk;

  clock_drift_generator #(
    .HALF_PERIOD_WIDTH (HPW),
    .DRIFT_WIDTH       (DW)
  ) dut (
    .sys_dom_i             (sys_dom),
    .gen_en_i              (gen_en),
    .clear_state_i         (clear_state),
    .high_half_period_i    (high_hp),
    .low_half_period_i     (low_hp),
    .drift_mode_i          (mode),
    .drift_step_i          (step),
    .drift_interval_i      (interval),
    .drift_limit_i         (limit),
    .io_clk_o              (io_clk),
    .io_events_o           (events),
    .accumulated_drift_o   (acc),
    .drift_limit_reached_o (reached)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Counts negedges while io_clk stays at lvl, with the edge pulses seen.
  task automatic run_len(input logic lvl, output int n, output int r, output int f);
    n = 0;
    r = 0;
    f = 0;
    while ((io_clk === lvl) && (n < 1000)) begin
      n++;
      r += int'(events.rising_edge);
      f += int'(events.falling_edge);
      @(negedge clk);
    end
  endtask

  task automatic measure(input string tag, input int idx, input int exp_len, input int exp_acc);
    int n, r, f;
    logic lvl;
    lvl = io_clk;
    check($sformatf("%s_acc%0d", tag, idx), acc, exp_acc);
    run_len(lvl, n, r, f);
    check($sformatf("%s_len%0d", tag, idx), n, exp_len);
    check($sformatf("%s_edge%0d", tag, idx), r + f, 1);
  endtask

  task automatic set_cfg(input int hi, input int lo, input int md, input int st,
                         input int iv, input int lm);
    high_hp  = HPW'(hi);
    low_hp   = HPW'(lo);
    mode     = 2'(md);
    step     = DW'(st);
    interval = HPW'(iv);
    limit    = DW'(lm);
  endtask

  task automatic stop_and_clear();
    gen_en      = 1'b0;
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r, f;
    gen_en      = 1'b0;
    clear_state = 1'b0;
    set_cfg(4, 6, 0, 0, 0, 5);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk", io_clk, 0);
    check("rst_events", {events.rising_edge, events.falling_edge, events.any_valid_edge}, 0);
    check("rst_acc", acc, 0);
    check("rst_reached", reached, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Steady clock 4 high / 6 low
    gen_en = 1'b1;
    @(negedge clk);
    check("steady_first_rise", events.rising_edge, 1);
    check("steady_first_any", events.any_valid_edge, 1);
    for (int p = 0; p < 2; p++) begin
      run_len(1'b1, n, r, f);
      check($sformatf("steady_high%0d", p), n, 4);
      check($sformatf("steady_high_rise%0d", p), r, 1);
      check($sformatf("steady_high_fall%0d", p), f, 0);
      run_len(1'b0, n, r, f);
      check($sformatf("steady_low%0d", p), n, 6);
      check($sformatf("steady_low_rise%0d", p), r, 0);
      check($sformatf("steady_low_fall%0d", p), f, 1);
    end

    // Ramp-up to +3, then stop mid-HIGH
    stop_and_clear();
    set_cfg(10, 10, 1, 1, 2, 3);
    gen_en = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("ramp_up_reached%0d", j), reached, (j >= 5) ? 1 : 0);
      measure("ramp_up", j, ru_len[j], ru_acc[j]);
    end
    check("stop_pre_clk", io_clk, 1);
    repeat (3) @(negedge clk);
    gen_en = 1'b0;
    @(negedge clk);
    check("stop_clk", io_clk, 0);
    check("stop_fall", events.falling_edge, 0);
    check("stop_any", events.any_valid_edge, 0);
    check("stop_acc_held", acc, 3);

    // Ramp-down to the floor
    stop_and_clear();
    check("clear_acc", acc, 0);
    set_cfg(2, 2, 2, 4, 1, 8);
    gen_en = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 6; j++) measure("ramp_down", j, rd_len[j], rd_acc[j]);
    check("ramp_down_reached", reached, 1);

    // Oscillate
    stop_and_clear();
    set_cfg(3, 3, 3, 2, 1, 4);
    gen_en = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 8; j++) measure("osc", j, os_len[j], os_acc[j]);

    // Clear coincident with a drift update on the falling edge
    stop_and_clear();
    set_cfg(4, 4, 1, 1, 1, 5);
    gen_en = 1'b1;
    @(negedge clk);
    check("clr_first_acc", acc, 1);
    repeat (3) @(negedge clk);
    check("clr_pre_clk", io_clk, 1);
    clear_state = 1'b1;
    @(negedge clk);
    clear_state = 1'b0;
    check("clr_acc", acc, 0);
    check("clr_fall", events.falling_edge, 1);
    run_len(1'b0, n, r, f);
    check("clr_low_len", n, 5);
    check("clr_next_acc", acc, 1);
    run_len(1'b1, n, r, f);
    check("clr_high_len", n, 4);
    check("clr_low2_acc", acc, 2);

    // Async reset mid-LOW
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_clk", io_clk, 0);
    check("arst_events", {events.rising_edge, events.falling_edge, events.any_valid_edge}, 0);
    check("arst_acc", acc, 0);
    check("arst_reached", reached, 0);
    gen_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_idle_clk", io_clk, 0);
    gen_en = 1'b1;
    @(negedge clk);
    check("restart_clk", io_clk, 1);
    check("restart_rise", events.rising_edge, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_drift_generator.md
CLOCK_DRIFT_GENERATOR -- requirements
Module: clock_drift_generator

Interface
REQ-001 SHALL have parameter HALF_PERIOD_WIDTH, default 16, giving the bit width of the half-period counters and inputs.
REQ-002 SHALL have parameter DRIFT_WIDTH, default 8, giving the bit width of the signed drift step, limit and accumulator.
REQ-003 SHALL have port sys_dom_i.clk, input, 1, the sole clock, rising edge (member of common_p::clk_dom_s).
REQ-004 SHALL have port sys_dom_i.rst_n, input, 1, the reset: asynchronous, active-low (member of common_p::clk_dom_s).
REQ-005 SHALL have port gen_en_i, input, 1, which runs the generator when high.
REQ-006 SHALL have port clear_state_i, input, 1, a synchronous clear of the drift accumulator and interval counter.
REQ-007 SHALL have port high_half_period_i, input, HALF_PERIOD_WIDTH, the base cycles io_clk_o is held high.
REQ-008 SHALL have port low_half_period_i, input, HALF_PERIOD_WIDTH, the base cycles io_clk_o is held low.
REQ-009 SHALL have port drift_mode_i, input, 2, selecting the drift mode: 0 none, 1 ramp-up, 2 ramp-down, 3 oscillate.
REQ-010 SHALL have port drift_step_i, input, DRIFT_WIDTH unsigned, the magnitude added per drift update.
REQ-011 SHALL have port drift_interval_i, input, HALF_PERIOD_WIDTH, the number of io_clk edges between drift updates.
REQ-012 SHALL have port drift_limit_i, input, DRIFT_WIDTH unsigned, the saturation magnitude of the accumulated drift.
REQ-013 SHALL have port io_clk_o, output, 1, the generated clock.
REQ-014 SHALL have port io_events_o, output, clks_alot_p::recovered_events_s, with fields rising_edge, falling_edge and any_valid_edge.
REQ-015 SHALL have port accumulated_drift_o, output, DRIFT_WIDTH signed, the current drift offset.
REQ-016 SHALL have port drift_limit_reached_o, output, 1, high while |accumulated drift| equals drift_limit_i.

Function
REQ-017 SHALL implement the FSM states IDLE, HIGH and LOW.
- IDLE->HIGH: gen_en_i=1.
- HIGH->LOW and LOW->HIGH: on half-period terminal count.
- Any state->IDLE: on the first cycle gen_en_i=0, regardless of position in the half period.
REQ-018 SHALL register io_clk_o: 1 in HIGH, 0 in IDLE and LOW.
REQ-019 SHALL pulse rising_edge (or falling_edge) for exactly one cycle, in the same cycle io_clk_o first shows the new level; any_valid_edge SHALL be the OR of the two.
REQ-020 SHALL hold io_clk_o at each level for exactly N cycles, where N = base half period + accumulated drift, clamped to [1, 2^HALF_PERIOD_WIDTH-1].
REQ-021 SHALL sample N at entry to each half period; changes to the inputs mid-half-period SHALL NOT affect the current half period.
REQ-022 SHALL count edges; after every drift_interval_i edges it SHALL update the drift accumulator and restart the edge count. drift_interval_i=0 SHALL disable updates.
REQ-023 SHALL update the accumulator by mode:
- Mode 1: add +step.
- Mode 2: add -step.
- Mode 0: hold.
REQ-024 SHALL saturate the accumulator at ±drift_limit_i; it SHALL never wrap.
REQ-025 In mode 3, the accumulator SHALL ramp up, reverse direction on reaching +limit, and reverse again on reaching -limit (triangle wave).
REQ-026 If clear_state_i and a drift update occur in the same cycle, clear_state_i SHALL take priority: accumulator 0, edge count 0, oscillate direction up.
REQ-027 A change of drift_limit_i below the current |accumulator| SHALL clamp the accumulator to the new limit on the next update.
REQ-028 On returning to IDLE, the generator SHALL hold the accumulator and emit no edge events.

Reset
REQ-029 On sys_dom_i.rst_n low, the block SHALL asynchronously set: state IDLE, io_clk_o 0, all io_events_o fields 0, accumulated_drift_o 0, drift_limit_reached_o 0, counters 0, oscillate direction up.
REQ-030 Reset SHALL deassert cleanly mid-operation; the first rising edge SHALL appear one cycle after gen_en_i is seen high.

Configuration
REQ-031 With CLKS_ALOT_DRIFT_OSCILLATE_EN defined, mode 3 SHALL behave per REQ-025; without it, mode 3 SHALL behave as mode 0 and the direction register SHALL be absent.

Structure
REQ-032 The shared package clks_alot_p SHALL hold recovered_events_s, the drift_mode_e enum and the default width constants.
REQ-033 The accumulator, saturation and oscillation logic SHALL be a sub-module named drift_accumulator.

Verification
REQ-034 The bench SHALL cover each of the following directed scenarios:
- Steady clock: high=4, low=6, mode 0 -> io_clk_o is 4 cycles high and 6 cycles low; one rising_edge and one falling_edge pulse per period.
- Ramp-up: high=low=10, step=1, interval=2, limit=3, mode 1 -> half periods 10,10,11,11,12,12,13,13,... stay at 13; drift_limit_reached_o rises when the accumulator reaches 3.
- Ramp-down to the floor: high=low=2, step=4, interval=1, limit=8, mode 2 -> half periods clamp to 1; accumulator saturates at -8.
- Oscillate (macro defined): step=2, limit=4, interval=1 -> accumulator 2,4,2,0,-2,-4,-2,...; without the macro it stays at 0.
- Stop and clear: gen_en_i dropped mid-HIGH -> io_clk_o is 0 the next cycle with no falling_edge pulse; clear_state_i coincident with an update -> accumulator 0.
- Async reset mid-LOW -> all outputs 0 immediately; restart produces rising_edge one cycle after gen_en_i.
